operand_load_unit: RTL
======================

Name: operand_load_unit

Overview:
- Consumer end of the controller's registered loadControl bus: takes a loadGroup code plus the instruction word and fetches/forms the two execute-stage operands (A, B).
- Reads the single-read-port register file (1-cycle synchronous read), extends immediates, and presents operands to execute with a valid/ready handshake.
- Sits between the controller output logic and the ALU/AGU operand registers.

Parameters:
- DATA_W, 32, operand and register width
- RF_ADDR_W, 5, register index width (32 registers)

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- enable  in  1  stall control; 0 freezes FSM and all registers
- load_valid  in  1  loadControl/instr/next_pc valid
- load_ready  out  1  unit can accept a load code
- load_control  in  loadGroup::controlBus  operand-load selection code
- instr  in  32  instruction word
- next_pc  in  32  PC of following instruction
- imm_zext  in  1  1 = zero-extend IMM16, 0 = sign-extend
- rf_rd_en  out  1  register file read strobe
- rf_rd_addr  out  RF_ADDR_W  register file read index
- rf_rd_data  in  DATA_W  read data, valid cycle after rf_rd_en; RF holds it while rf_rd_en=0
- operand_a  out  DATA_W  operand A
- operand_b  out  DATA_W  operand B
- operand_valid  out  1  operands valid
- operand_ready  in  1  execute accepts operands

Behaviour:
- Reset (async, reset_n=0): state IDLE; operand_a/b=0, operand_valid=0, rf_rd_en=0, rf_rd_addr=0; load_ready=0 while in reset.
- Fields: regA=instr[23:19], regB=instr[18:14], imm24=[23:0], imm21=[20:0], imm19=[18:0], imm16=[15:0], imm5=[4:0].
- Extension: IMM24/IMM21/IMM19 sign-extended then <<2; IMM16 per imm_zext; IMM5 zero-extended; all truncated to DATA_W.
- Code mapping: NEXTPC_IMMx: A=next_pc, B=ext(imm); RFA_IMMx: A=RF[regA], B=ext(imm); RFA_RFB: A=RF[regA], B=RF[regB]; RFA_NULL: A=RF[regA], B=0; COMBO_NULL: A={imm16,16'h0}, B=0.
- load_ready = enable && state==IDLE. Accept = load_valid && load_ready; code, instr, next_pc, imm_zext latched on accept.
- NO_OP accepted: no state change, no outputs change.
- FSM states: IDLE, READ_A, READ_B, CAPTURE, DONE.
  - IDLE: accept, code needs no RF -> operands written, go DONE (operand_valid 1 cycle after accept); needs RF -> READ_A.
  - READ_A: rf_rd_en=1, addr=regA; B immediate written here; RFA_RFB -> READ_B, else CAPTURE.
  - READ_B: operand_a<=rf_rd_data; rf_rd_en=1, addr=regB; -> CAPTURE.
  - CAPTURE: rf_rd_data into operand_b if RFA_RFB, else operand_a; -> DONE.
  - DONE: operand_valid=1; operand_ready=1 -> IDLE, operand_valid falls next cycle; else hold.
- Latency accept->operand_valid: no-RF 1, single-RF 3, RFA_RFB 4 cycles.
- enable=0: state, operands, latched fields frozen; rf_rd_en forced 0; operand_valid held; resumes exactly where stopped (RF output hold covers pending capture).
- operand_a/b stable and unchanged while operand_valid=1 and operand_ready=0.
- regA==regB on RFA_RFB: two reads still issued, both operands equal.
- Reset mid-operation: immediate return to IDLE, in-flight load discarded.

Decomposition:
- Package operandLoadPkg: state enum, field position constants, extension helper function; loadGroup codes reused unchanged from loadGroup.
- One sub-module: imm_extend (combinational code + imm_zext -> 32-bit B-side immediate).

Test Plan:
- NEXTPC_IMM24, next_pc=0x00001000, imm24=0xFFFFFF -> 1 cycle later A=0x00001000, B=0xFFFFFFFC, valid=1, no rf_rd_en.
- RFA_RFB, regA=3 (0x11), regB=4 (0x22) -> rf_rd_addr 3 then 4 on consecutive cycles, A=0x11, B=0x22, valid 4 cycles after accept.
- RFA_IMM16, regA=1 (0x10), imm16=0x8000, imm_zext=0 then 1 -> B=0xFFFF8000, then 0x00008000; A=0x10; valid after 3 cycles.
- COMBO_NULL imm16=0xABCD with operand_ready=0 for 5 cycles -> A=0xABCD0000, B=0 held, load_ready=0 until handshake completes.
- RFA_RFB with enable=0 for 3 cycles in READ_B -> rf_rd_en=0 during stall, final A/B correct, latency extended by exactly 3.
- reset_n low while in READ_B -> outputs 0, IDLE; next RFA_NULL load completes normally with B=0.

Source files
------------

// File: rtl/operand_load_unit_pkg.sv
// Shared types and helpers for the operand load unit.
//   load_group_e : operand-load selection codes carried on the loadControl bus
//   state_e      : load FSM states
//   ext_imm()    : forms the 32-bit B-side immediate for a load code
package operand_load_unit_pkg;

  typedef enum logic [3:0] {
    LgNoOp,
    LgNextpcImm24,
    LgNextpcImm21,
    LgNextpcImm19,
    LgNextpcImm16,
    LgNextpcImm5,
    LgRfaImm24,
    LgRfaImm21,
    LgRfaImm19,
    LgRfaImm16,
    LgRfaImm5,
    LgRfaRfb,
    LgRfaNull,
    LgComboNull
  } load_group_e;

  typedef enum logic [2:0] {
    StIdle,
    StReadA,
    StReadB,
    StCapture,
    StDone
  } state_e;

  // Instruction field positions
  localparam int unsigned RegAMsb   = 23;
  localparam int unsigned RegALsb   = 19;
  localparam int unsigned RegBMsb   = 18;
  localparam int unsigned RegBLsb   = 14;
  // Every field the unit uses after accept lives in instr[23:0]
  localparam int unsigned ImmFieldW = 24;

  // Branch-style immediates are word offsets: sign-extend, then scale by 4.
  function automatic logic [31:0] ext_imm(input load_group_e          code,
                                          input logic [ImmFieldW-1:0] f,
                                          input logic                 zext);
    logic [31:0] r;
    r = '0;
    case (code)
      LgNextpcImm24, LgRfaImm24: r = {{6{f[23]}}, f[23:0], 2'b00};
      LgNextpcImm21, LgRfaImm21: r = {{9{f[20]}}, f[20:0], 2'b00};
      LgNextpcImm19, LgRfaImm19: r = {{11{f[18]}}, f[18:0], 2'b00};
      LgNextpcImm16, LgRfaImm16: r = zext ? {16'h0000, f[15:0]} : {{16{f[15]}}, f[15:0]};
      LgNextpcImm5,  LgRfaImm5:  r = {27'h0, f[4:0]};
      default:                   r = '0;
    endcase
    return r;
  endfunction

  function automatic logic is_nextpc(input load_group_e code);
    return code inside {LgNextpcImm24, LgNextpcImm21, LgNextpcImm19, LgNextpcImm16,
                        LgNextpcImm5};
  endfunction

  function automatic logic needs_rf(input load_group_e code);
    return code inside {LgRfaImm24, LgRfaImm21, LgRfaImm19, LgRfaImm16, LgRfaImm5,
                        LgRfaRfb, LgRfaNull};
  endfunction

endpackage

// File: rtl/operand_load_unit_imm_extend.sv
// Combinational B-side immediate former.
//   code     : load selection code
//   field    : instr[23:0]
//   imm_zext : 1 = zero-extend IMM16, 0 = sign-extend
//   imm      : extended immediate, truncated to DATA_W (0 for non-immediate codes)
module operand_load_unit_imm_extend
  import operand_load_unit_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  load_group_e                code,
  input  logic [ImmFieldW-1:0]       field,
  input  logic                       imm_zext,
  output logic [DATA_W-1:0]          imm
);

  logic [31:0] imm32;

  assign imm32 = ext_imm(code, field, imm_zext);
  assign imm   = DATA_W'(imm32);

endmodule

// File: rtl/operand_load_unit.sv
// Operand load unit: turns a loadControl code plus instruction word into the two
// execute-stage operands, reading the single-port register file when needed.
//   clk, reset_n              : clock, asynchronous active-low reset
//   enable                    : 0 freezes FSM and all registers
//   load_valid / load_ready   : load code handshake
//   load_control, instr,
//   next_pc, imm_zext         : load request fields (latched on accept)
//   rf_rd_en/addr/data        : register file read port (1-cycle synchronous read)
//   operand_a/b, operand_valid,
//   operand_ready             : operand handshake towards execute
module operand_load_unit
  import operand_load_unit_pkg::*;
#(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned RF_ADDR_W = 5
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 enable,
  input  logic                 load_valid,
  output logic                 load_ready,
  input  load_group_e          load_control,
  input  logic [31:0]          instr,
  input  logic [31:0]          next_pc,
  input  logic                 imm_zext,
  output logic                 rf_rd_en,
  output logic [RF_ADDR_W-1:0] rf_rd_addr,
  input  logic [DATA_W-1:0]    rf_rd_data,
  output logic [DATA_W-1:0]    operand_a,
  output logic [DATA_W-1:0]    operand_b,
  output logic                 operand_valid,
  input  logic                 operand_ready
);

  state_e                 state_q;
  load_group_e            code_q;
  logic [ImmFieldW-1:0]   field_q;
  logic                   zext_q;

  load_group_e            ext_code;
  logic [ImmFieldW-1:0]   ext_field;
  logic                   ext_zext;
  logic [DATA_W-1:0]      imm_b;

  // next_pc is consumed on the accept edge itself, so it is never held.
  // The opcode byte is decoded upstream into load_control.
  logic unused_instr_hi;
  assign unused_instr_hi = ^instr[31:24];

  assign load_ready = reset_n && enable && (state_q == StIdle);
  // Gated by enable so a stall never issues a second read; the RF holds its data.
  assign rf_rd_en   = enable && ((state_q == StReadA) || (state_q == StReadB));

  // In IDLE the immediate comes straight from the request (no-RF codes finish
  // on the accept edge); afterwards from the latched copy.
  assign ext_code  = (state_q == StIdle) ? load_control            : code_q;
  assign ext_field = (state_q == StIdle) ? instr[ImmFieldW-1:0]    : field_q;
  assign ext_zext  = (state_q == StIdle) ? imm_zext                : zext_q;

  operand_load_unit_imm_extend #(
    .DATA_W (DATA_W)
  ) u_imm_extend (
    .code     (ext_code),
    .field    (ext_field),
    .imm_zext (ext_zext),
    .imm      (imm_b)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= StIdle;
      code_q        <= LgNoOp;
      field_q       <= '0;
      zext_q        <= 1'b0;
      operand_a     <= '0;
      operand_b     <= '0;
      operand_valid <= 1'b0;
      rf_rd_addr    <= '0;
    end else if (enable) begin
      case (state_q)
        StIdle: begin
          if (load_valid) begin
            code_q  <= load_control;
            field_q <= instr[ImmFieldW-1:0];
            zext_q  <= imm_zext;
            if (is_nextpc(load_control)) begin
              operand_a     <= DATA_W'(next_pc);
              operand_b     <= imm_b;
              operand_valid <= 1'b1;
              state_q       <= StDone;
            end else if (load_control == LgComboNull) begin
              operand_a     <= DATA_W'({instr[15:0], 16'h0000});
              operand_b     <= '0;
              operand_valid <= 1'b1;
              state_q       <= StDone;
            end else if (needs_rf(load_control)) begin
              rf_rd_addr <= RF_ADDR_W'(instr[RegAMsb:RegALsb]);
              state_q    <= StReadA;
            end
            // NO_OP and unused codes: accepted, nothing else changes
          end
        end
        StReadA: begin
          if (code_q == LgRfaRfb) begin
            rf_rd_addr <= RF_ADDR_W'(field_q[RegBMsb:RegBLsb]);
            state_q    <= StReadB;
          end else begin
            operand_b <= imm_b;  // 0 for RFA_NULL
            state_q   <= StCapture;
          end
        end
        StReadB: begin
          operand_a <= rf_rd_data;
          state_q   <= StCapture;
        end
        StCapture: begin
          if (code_q == LgRfaRfb) begin
            operand_b <= rf_rd_data;
          end else begin
            operand_a <= rf_rd_data;
          end
          operand_valid <= 1'b1;
          state_q       <= StDone;
        end
        StDone: begin
          if (operand_ready) begin
            operand_valid <= 1'b0;
            state_q       <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
